// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA timing generator with pixel request and registered RGB output
//
// Purpose: free-running H/V counters for a 640x480@60Hz raster. The block asks
// the picture generator for a pixel one clock ahead (pix_req/pix_x/pix_y) and
// registers the returned pix_data onto rgb, aligned with the sync outputs.
//
// Ports:
//   vga_clk     in   pixel clock
//   sys_rst_n   in   asynchronous active-low reset
//   pix_data    in   RGB888 for the requested pixel, combinational reply
//   pix_x/pix_y out  requested coordinates, 10'h3FF when no request
//   pix_req     out  request strobe
//   hsync/vsync out  sync pulses, active level SYNC_POL
//   rgb         out  pixel colour, 0 outside the active window
//   rgb_valid   out  rgb holds an active pixel
//   frame_start out  one-clock pulse at count (0,0)
module vga_ctrl #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_VALID  = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_VALID  = 480,
  parameter int   V_FRONT  = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST  = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [9:0] V_LAST  = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);
  localparam logic [9:0] HS      = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HE      = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] VS      = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VE      = 10'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0] NO_REQ  = 10'h3FF;

  // run_q is low only for the first edge after reset, so that edge lands
  // the counters on (0,0) and the registered decodes show the frame start.
  logic        run_q, run_d;
  logic [9:0]  cnt_h_q, cnt_h_d;
  logic [9:0]  cnt_v_q, cnt_v_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;
  logic        rgb_valid_q, rgb_valid_d;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    run_d   = 1'b1;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    if (!run_q) begin
      cnt_h_d = '0;
      cnt_v_d = '0;
    end else if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 10'd1;
    end else begin
      cnt_h_d = cnt_h_q + 10'd1;
    end
  end

  // Registered outputs decode the next count, so each flop reflects the
  // count held in the counter registers on the same clock.
  always_comb begin
    hsync_d       = (cnt_h_d < H_SW) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (cnt_v_d < V_SW) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = (cnt_h_d == '0) && (cnt_v_d == '0);
    rgb_valid_d   = (cnt_h_d >= HS) && (cnt_h_d < HE) &&
                    (cnt_v_d >= VS) && (cnt_v_d < VE);
  end

  // Request window leads the display window by one clock to cover the
  // rgb register latency.
  always_comb begin
    pix_req = (cnt_h_q >= HS - 10'd1) && (cnt_h_q < HE - 10'd1) &&
              (cnt_v_q >= VS) && (cnt_v_q < VE);
    pix_x   = pix_req ? cnt_h_q - (HS - 10'd1) : NO_REQ;
    pix_y   = pix_req ? cnt_v_q - VS : NO_REQ;
    rgb_d   = pix_req ? pix_data : 24'h0;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q         <= 1'b0;
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      rgb_valid_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      run_q         <= run_d;
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      rgb_valid_q   <= rgb_valid_d;
      rgb_q         <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign rgb_valid   = rgb_valid_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - self-checking bench for vga_ctrl with an rgb scoreboard
module tb_vga_ctrl;

  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_VALID = 640;
  localparam int H_FRONT = 16;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 3;
  localparam int V_VALID = 6;
  localparam int V_FRONT = 2;
  localparam int HT      = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int VT      = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int HSS     = H_SYNC + H_BACK;
  localparam int VSS     = V_SYNC + V_BACK;
  localparam int FRAME   = HT * VT;

  logic        clk;
  logic        rst_n;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        pix_req, hsync, vsync, rgb_valid, frame_start;
  logic [23:0] rgb;
  int          mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pix_data = (mode == 1) ? 24'hFFFFFF : {pix_y, 4'h0, pix_x};

  vga_ctrl #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_VALID(H_VALID), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_VALID(V_VALID), .V_FRONT(V_FRONT),
    .SYNC_POL(1'b0)
  ) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .rgb_valid(rgb_valid),
    .frame_start(frame_start)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference raster position: first edge after release is (0,0).
  logic m_run;
  int   mh, mv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; mh <= 0; mv <= 0;
    end else if (!m_run) begin
      m_run <= 1'b1; mh <= 0; mv <= 0;
    end else if (mh == HT - 1) begin
      mh <= 0;
      mv <= (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  logic [23:0] sb[$];

  initial begin : monitor
    int cyc, hs_low, vs_low, last_hfall, last_fs, line_val;
    logic prev_hs, prev_vs;
    logic e_hs, e_vs, e_fs, e_val, e_req, v_req;
    logic [9:0] e_x, e_y;
    logic [23:0] e_rgb;
    cyc = 0; hs_low = 0; vs_low = 0; last_hfall = -1; last_fs = -1; line_val = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
    #2;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hs_low = 0; vs_low = 0; last_hfall = -1; last_fs = -1; line_val = 0;
        sb.delete();
      end
      e_hs  = m_run ? (mh < H_SYNC ? 1'b0 : 1'b1) : 1'b1;
      e_vs  = m_run ? (mv < V_SYNC ? 1'b0 : 1'b1) : 1'b1;
      e_fs  = m_run && mh == 0 && mv == 0;
      e_val = m_run && mh >= HSS && mh < HSS + H_VALID && mv >= VSS && mv < VSS + V_VALID;
      v_req = mv >= VSS && mv < VSS + V_VALID;
      e_req = m_run && mh >= HSS - 1 && mh < HSS + H_VALID - 1 && v_req;
      e_x   = e_req ? 10'(mh - (HSS - 1)) : 10'h3FF;
      e_y   = e_req ? 10'(mv - VSS) : 10'h3FF;
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("frame_start", frame_start, e_fs);
      check("rgb_valid", rgb_valid, e_val);
      check("pix_req", pix_req, e_req);
      check("pix_x", pix_x, e_x);
      check("pix_y", pix_y, e_y);
      if (e_val) begin
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else begin
          e_rgb = sb.pop_front();
          check("rgb", rgb, e_rgb);
        end
      end else begin
        check("rgb_blank", rgb, 0);
      end
      if (e_req) sb.push_back((mode == 1) ? 24'hFFFFFF : {e_y, 4'h0, e_x});
      if (rst_n) begin
        if (hsync == 1'b0) hs_low++;
        else if (prev_hs == 1'b0) begin check("hs_low_width", hs_low, H_SYNC); hs_low = 0; end
        if (vsync == 1'b0) vs_low++;
        else if (prev_vs == 1'b0) begin check("vs_low_width", vs_low, V_SYNC * HT); vs_low = 0; end
        if (prev_hs == 1'b1 && hsync == 1'b0) begin
          if (last_hfall >= 0) check("hs_period", cyc - last_hfall, HT);
          last_hfall = cyc;
          if (line_val > 0) check("line_valid", line_val, H_VALID);
          line_val = 0;
        end
        if (rgb_valid) line_val++;
        if (frame_start) begin
          if (last_fs >= 0) check("fs_period", cyc - last_fs, FRAME);
          check("fs_hsync_low", hsync, 0);
          check("fs_vsync_low", vsync, 0);
          last_fs = cyc;
        end
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
  end

  initial begin : stim
    int n;
    mode  = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_pix_x", pix_x, 10'h3FF);
    check("rst_pix_y", pix_y, 10'h3FF);
    check("rst_frame_start", frame_start, 0);
    check("rst_pix_req", pix_req, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_fs", frame_start, 1);
    check("first_hsync", hsync, 0);
    check("first_vsync", vsync, 0);

    repeat (2 * FRAME) @(posedge clk);
    #2 mode = 1;
    repeat (FRAME) @(posedge clk);
    #2 mode = 0;

    n = 0;
    while (!(mh == 400 && mv == VSS + 2) && n < 2 * FRAME) begin
      @(posedge clk); #2;
      n++;
    end
    check("wait_mid_frame", n < 2 * FRAME, 1);
    check("mid_rgb_active", rgb_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rgb", rgb, 0);
    check("async_rgb_valid", rgb_valid, 0);
    check("async_hsync", hsync, 1);
    check("async_vsync", vsync, 1);
    check("async_pix_req", pix_req, 0);
    check("async_pix_x", pix_x, 10'h3FF);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_fs", frame_start, 1);
    repeat (FRAME + 2 * HT) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
